// File: rtl/calc_key_entry.sv
// Keypad front end for a three-digit integer calculator.
// Debounces key presses and releases, then runs a small entry FSM that
// builds two operands, applies add/sub/mul, and drives a registered
// display value in the 0-999 range.
module calc_key_entry #(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] keycode,
  output logic [9:0] display_value,
  output logic       key_accept,
  output logic       error,
  output logic [1:0] state_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_MUL = 4'hC;
  localparam logic [3:0] K_EQ  = 4'hD;
  localparam logic [3:0] K_BS  = 4'hE;
  localparam logic [3:0] K_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_SHOW    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Debounce state
  // arm_q   : 1 = waiting for a stable press, 0 = waiting for a stable release
  // fresh_q : a low level has been seen since reset/re-arm, so a press that
  //           was already held across reset can never be accepted
  // cnt_q   : shared counter for press and release qualification
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [3:0]    code_q, code_d;
  logic          arm_q, arm_d;
  logic          fresh_q, fresh_d;
  logic          accept;

  // Press/release qualification; accept fires on the last stable press cycle
  always_comb begin
    cnt_d   = cnt_q;
    code_d  = code_q;
    arm_d   = arm_q;
    fresh_d = fresh_q;
    accept  = 1'b0;
    cnt_nx  = cnt_q + CW'(1);
    if (arm_q) begin
      if (!key_pressed) begin
        cnt_d   = '0;
        fresh_d = 1'b1;
      end else if (fresh_q) begin
        // a changed code restarts the press qualification
        cnt_nx = (cnt_q != '0 && keycode == code_q) ? cnt_q + CW'(1) : CW'(1);
        code_d = keycode;
        if (cnt_nx == DB_MAX) begin
          accept = 1'b1;
          arm_d  = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_nx;
        end
      end
    end else begin
      // disarmed: code changes while held are ignored until a stable release
      if (key_pressed) begin
        cnt_d = '0;
      end else if (cnt_nx == DB_MAX) begin
        arm_d   = 1'b1;
        fresh_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_nx;
      end
    end
  end

  // Debounce registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      code_q  <= '0;
      arm_q   <= 1'b1;
      fresh_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      arm_q   <= arm_d;
      fresh_q <= fresh_d;
    end
  end

  // ---------------------------------------------------------------------
  // Calculator datapath
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [9:0]  acc_a_q, acc_a_d;
  logic [9:0]  acc_b_q, acc_b_d;
  logic [1:0]  op_q, op_d;
  logic [9:0]  disp_q, disp_d;
  logic        key_accept_q, key_accept_d;
  logic        error_q, error_d;

  logic [19:0] a20, b20, res, a_app, b_app;
  logic        neg, ovf;
  logic        is_digit, is_op;
  logic [1:0]  key_op;

  // Operand arithmetic in 20 bits so 999*999 and digit appends never wrap
  always_comb begin
    a20   = {10'd0, acc_a_q};
    b20   = {10'd0, acc_b_q};
    a_app = a20 * 20'd10 + {16'd0, code_q};
    b_app = b20 * 20'd10 + {16'd0, code_q};
    neg   = 1'b0;
    case (op_q)
      OP_SUB: begin
        res = a20 - b20;
        neg = (a20 < b20);
      end
      OP_MUL:  res = a20 * b20;
      default: res = a20 + b20;
    endcase
    ovf = neg || (res > 20'd999);
  end

  // Key classification on the qualified code
  always_comb begin
    is_digit = (code_q <= 4'd9);
    is_op    = (code_q == K_ADD) || (code_q == K_SUB) || (code_q == K_MUL);
    case (code_q)
      K_SUB:   key_op = OP_SUB;
      K_MUL:   key_op = OP_MUL;
      default: key_op = OP_ADD;
    endcase
  end

  // Entry FSM next state; outputs are computed here and registered with state
  always_comb begin
    state_d      = state_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    op_d         = op_q;
    disp_d       = disp_q;
    key_accept_d = 1'b0;
    if (accept) begin
      key_accept_d = 1'b1;
      if (code_q == K_CLR) begin
        state_d = ST_ENTER_A;
        acc_a_d = '0;
        acc_b_d = '0;
        op_d    = OP_ADD;
        disp_d  = '0;
      end else begin
        case (state_q)
          ST_ENTER_A: begin
            if (is_digit) begin
              if (a_app <= 20'd999) acc_a_d = a_app[9:0];
              disp_d = acc_a_d;
            end else if (is_op) begin
              op_d    = key_op;
              acc_b_d = '0;
              state_d = ST_ENTER_B;
              disp_d  = acc_a_q;
            end else if (code_q == K_BS) begin
              acc_a_d = acc_a_q / 10'd10;
              disp_d  = acc_a_d;
            end
          end
          ST_ENTER_B: begin
            if (is_digit) begin
              if (b_app <= 20'd999) acc_b_d = b_app[9:0];
              disp_d = acc_b_d;
            end else if (code_q == K_BS) begin
              acc_b_d = acc_b_q / 10'd10;
              disp_d  = acc_b_d;
            end else if (is_op || code_q == K_EQ) begin
              if (ovf) begin
                // accumulators keep their values; only F recovers
                state_d = ST_ERROR;
                disp_d  = '0;
              end else begin
                acc_a_d = res[9:0];
                disp_d  = res[9:0];
                if (is_op) begin
                  op_d    = key_op;
                  acc_b_d = '0;
                end else begin
                  state_d = ST_SHOW;
                end
              end
            end
          end
          ST_SHOW: begin
            if (is_digit) begin
              acc_a_d = {6'd0, code_q};
              state_d = ST_ENTER_A;
              disp_d  = acc_a_d;
            end else if (is_op) begin
              op_d    = key_op;
              acc_b_d = '0;
              state_d = ST_ENTER_B;
              disp_d  = acc_a_q;
            end
          end
          default: ;
        endcase
      end
    end
    error_d = (state_d == ST_ERROR);
  end

  // Calculator registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ENTER_A;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      op_q         <= OP_ADD;
      disp_q       <= '0;
      key_accept_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      op_q         <= op_d;
      disp_q       <= disp_d;
      key_accept_q <= key_accept_d;
      error_q      <= error_d;
    end
  end

  assign display_value = disp_q;
  assign key_accept    = key_accept_q;
  assign error         = error_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry with a short debounce window.
module tb_calc_key_entry;

  logic       Clk;
  logic       reset;
  logic       key_pressed;
  logic [3:0] keycode;
  logic [9:0] display_value;
  logic       key_accept;
  logic       error;
  logic [1:0] state_out;

  int total = 0;
  int bad   = 0;
  int seen  = 0;

  calc_key_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk           (Clk),
    .reset         (reset),
    .key_pressed   (key_pressed),
    .keycode       (keycode),
    .display_value (display_value),
    .key_accept    (key_accept),
    .error         (error),
    .state_out     (state_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // hold a level for n cycles, counting accept pulses sampled after each edge
  task automatic drive(input logic p, input logic [3:0] k, input int n);
    key_pressed = p;
    keycode     = k;
    repeat (n) begin
      @(posedge Clk);
      #1;
      if (key_accept) seen++;
    end
  endtask

  task automatic press(input logic [3:0] k);
    drive(1'b1, k, 6);
    drive(1'b0, k, 6);
  endtask

  // one clean press: exactly one accept, then the displayed value
  task automatic key(input string tag, input logic [3:0] k, input logic [9:0] disp);
    seen = 0;
    press(k);
    chk({tag, "_acc"}, seen, 1);
    chk({tag, "_disp"}, display_value, disp);
  endtask

  initial begin
    reset       = 1'b0;
    key_pressed = 1'b0;
    keycode     = 4'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_disp", display_value, 0);
    chk("rst_acc", key_accept, 0);
    chk("rst_err", error, 0);
    chk("rst_state", state_out, 0);
    reset = 1'b1;
    drive(1'b0, 4'd0, 2);

    // digit entry
    key("d1", 4'd1, 1);
    key("d12", 4'd2, 12);
    key("d123", 4'd3, 123);
    key("clr0", 4'hF, 0);

    // long hold and short release glitch
    seen = 0;
    drive(1'b1, 4'd7, 100);
    chk("hold_one", seen, 1);
    chk("hold_disp", display_value, 7);
    seen = 0;
    drive(1'b0, 4'd7, 3);
    drive(1'b1, 4'd7, 20);
    drive(1'b0, 4'd7, 6);
    chk("glitch_none", seen, 0);
    chk("glitch_disp", display_value, 7);
    key("clr1", 4'hF, 0);

    // code change mid-debounce restarts; code change while held is ignored
    seen = 0;
    drive(1'b1, 4'd3, 2);
    drive(1'b1, 4'd4, 6);
    drive(1'b0, 4'd4, 6);
    chk("restart_acc", seen, 1);
    chk("restart_disp", display_value, 4);
    seen = 0;
    drive(1'b1, 4'd5, 6);
    drive(1'b1, 4'd6, 10);
    drive(1'b0, 4'd6, 6);
    chk("heldchg_acc", seen, 1);
    chk("heldchg_disp", display_value, 45);
    key("clr2", 4'hF, 0);

    // 12 + 30 = 42
    key("s1", 4'd1, 1);
    key("s12", 4'd2, 12);
    key("sadd", 4'hA, 12);
    chk("sadd_state", state_out, 1);
    key("s3", 4'd3, 3);
    key("s30", 4'd0, 30);
    key("seq", 4'hD, 42);
    chk("seq_state", state_out, 2);

    // 5 - 9 underflows into ERROR
    key("u5", 4'd5, 5);
    chk("u5_state", state_out, 0);
    key("usub", 4'hB, 5);
    key("u9", 4'd9, 9);
    key("ueq", 4'hD, 0);
    chk("ueq_err", error, 1);
    chk("ueq_state", state_out, 3);
    key("uign", 4'd4, 0);
    chk("uign_err", error, 1);
    chk("uign_state", state_out, 3);
    key("uclr", 4'hF, 0);
    chk("uclr_state", state_out, 0);
    chk("uclr_err", error, 0);

    // 50 * 20 = 1000 overflows
    key("o5", 4'd5, 5);
    key("o50", 4'd0, 50);
    key("omul", 4'hC, 50);
    key("o2", 4'd2, 2);
    key("o20", 4'd0, 20);
    key("oeq", 4'hD, 0);
    chk("oeq_err", error, 1);
    chk("oeq_state", state_out, 3);
    key("oclr", 4'hF, 0);

    // entry saturates at 999; extra digit still accepted; backspace
    key("n9", 4'd9, 9);
    key("n99", 4'd9, 99);
    key("n999", 4'd9, 999);
    key("n9999", 4'd9, 999);
    key("nbs", 4'hE, 99);
    key("nclr", 4'hF, 0);

    // chained 2*3 -> 6, then 6+4 = 10
    key("c2", 4'd2, 2);
    key("cmul", 4'hC, 2);
    key("c3", 4'd3, 3);
    key("cadd", 4'hA, 6);
    chk("cadd_state", state_out, 1);
    key("c4", 4'd4, 4);
    key("ceq", 4'hD, 10);
    chk("ceq_state", state_out, 2);

    // reset in the middle of a press
    seen = 0;
    drive(1'b1, 4'd5, 2);
    reset = 1'b0;
    #2;
    chk("mrst_disp", display_value, 0);
    chk("mrst_state", state_out, 0);
    chk("mrst_err", error, 0);
    chk("mrst_acc", key_accept, 0);
    drive(1'b1, 4'd5, 2);
    reset = 1'b1;
    drive(1'b1, 4'd5, 20);
    chk("mrst_noacc", seen, 0);
    chk("mrst_hold_disp", display_value, 0);
    drive(1'b0, 4'd5, 6);
    key("mrst_repress", 4'd5, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop so the bench always terminates
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
